norm_seq: RTL and testbench

Iterative normalization sequencer for the single-precision datapath. It accepts an unnormalized result (sign, 8-bit biased exponent, 24-bit significand with explicit integer bit) from the add/mul stages. It shifts the significand left one bit (or one nibble) per cycle, decrementing the exponent, until the integer bit is set, the value is zero, or the exponent bottoms out (denormal). It then presents a packed IEEE-754 word behind a valid/ready handshake, serializing the shared normalization resource between upstream and downstream.

---
 rtl/fp_pkg.sv | 30 +++
 rtl/norm_seq_if.sv | 25 ++
 rtl/norm_step.sv | 50 +++++
 rtl/norm_seq.sv | 99 +++++++++
 tb/tb_norm_seq.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision field widths, packed-word layout and the
// normalization sequencer state encoding.
`timescale 1ns/1ps
package fp_pkg;
  localparam int EXP_W    = 8;
  localparam int SIG_W    = 24;
  localparam int FRAC_W   = 23;
  localparam int WORD_W   = 1 + EXP_W + FRAC_W;
  localparam int SIGN_BIT = WORD_W - 1;
  localparam int EXP_LSB  = FRAC_W;
  localparam int SHIFT_W  = 5;
  localparam int INC_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } norm_state_t;

  function automatic logic [WORD_W-1:0] pack_float(input logic             s,
                                                   input logic [EXP_W-1:0]  e,
                                                   input logic [FRAC_W-1:0] f);
    logic [WORD_W-1:0] w;
    w                    = '0;
    w[SIGN_BIT]          = s;
    w[EXP_LSB +: EXP_W]  = e;
    w[FRAC_W-1:0]        = f;
    return w;
  endfunction
endpackage

// File: rtl/norm_seq_if.sv
// Operand-in / packed-result-out handshake bundle of the normalization sequencer.
`timescale 1ns/1ps
interface norm_seq_if;
  import fp_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sign;
  logic [EXP_W-1:0]     in_exp;
  logic [SIG_W-1:0]     in_sig;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_W-1:0]    out_word;
  logic [SHIFT_W-1:0]   out_shift;

  modport master (
    output in_valid, in_sign, in_exp, in_sig, out_ready,
    input  in_ready, out_valid, out_word, out_shift
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_sig, out_ready,
    output in_ready, out_valid, out_word, out_shift
  );
endinterface

// File: rtl/norm_step.sv
// One combinational normalization step; the nibble-wide shift exists only
// when NORM_FAST_EN is defined.
`timescale 1ns/1ps
module norm_step
  import fp_pkg::*;
(
  input  logic [SIG_W-1:0] sig_i,
  input  logic [EXP_W-1:0] exp_i,
  output logic [SIG_W-1:0] sig_o,
  output logic [EXP_W-1:0] exp_o,
  output logic [INC_W-1:0] inc_o,
  output logic             done_o,
  output logic             zero_o,
  output logic             denorm_o
);

  always_comb begin
    sig_o    = sig_i;
    exp_o    = exp_i;
    inc_o    = '0;
    done_o   = 1'b0;
    zero_o   = 1'b0;
    denorm_o = 1'b0;
    if (sig_i == '0) begin
      exp_o  = '0;
      done_o = 1'b1;
      zero_o = 1'b1;
    end else if (sig_i[SIG_W-1]) begin
      done_o = 1'b1;
    end else if (exp_i <= 8'd1) begin
      // Exponent floor reached: emit as denormal without further shifting.
      exp_o    = '0;
      done_o   = 1'b1;
      denorm_o = 1'b1;
    end
`ifdef NORM_FAST_EN
    else if (sig_i[SIG_W-1 -: 4] == 4'd0 && exp_i >= 8'd5) begin
      sig_o = sig_i << 4;
      exp_o = exp_i - 8'd4;
      inc_o = 3'd4;
    end
`endif
    else begin
      sig_o = sig_i << 1;
      exp_o = exp_i - 8'd1;
      inc_o = 3'd1;
    end
  end

endmodule

// File: rtl/norm_seq.sv
// Iterative normalization sequencer: IDLE -> SHIFT (one step per cycle) -> DONE.
// Define NORM_FAST_EN to enable nibble-wide steps (same results, lower latency).
`timescale 1ns/1ps
module norm_seq
  import fp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  norm_seq_if.slave  nif,
  output logic       busy
);

  norm_state_t          state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [WORD_W-1:0]    out_word_q;
  logic [SHIFT_W-1:0]   out_shift_q;
  logic                 sign_q;
  logic [EXP_W-1:0]     exp_q;
  logic [SIG_W-1:0]     sig_q;
  logic [SHIFT_W-1:0]   cnt_q;

  logic [SIG_W-1:0]     sig_d;
  logic [EXP_W-1:0]     exp_d;
  logic [INC_W-1:0]     inc_d;
  logic                 done_d;
  logic                 zero_d;
  logic                 denorm_d;
  logic [EXP_W-1:0]     exp_fin;

  norm_step u_step (
    .sig_i    (sig_q),
    .exp_i    (exp_q),
    .sig_o    (sig_d),
    .exp_o    (exp_d),
    .inc_o    (inc_d),
    .done_o   (done_d),
    .zero_o   (zero_d),
    .denorm_o (denorm_d)
  );

  assign exp_fin = (zero_d || denorm_d) ? '0 : exp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_shift_q <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      sig_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (nif.in_valid && in_ready_q) begin
            sign_q     <= nif.in_sign;
            exp_q      <= nif.in_exp;
            sig_q      <= nif.in_sig;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (done_d) begin
            out_valid_q <= 1'b1;
            out_word_q  <= pack_float(sign_q, exp_fin, sig_d[FRAC_W-1:0]);
            out_shift_q <= zero_d ? '0 : cnt_q;
            state_q     <= ST_DONE;
          end else begin
            sig_q <= sig_d;
            exp_q <= exp_d;
            cnt_q <= cnt_q + SHIFT_W'(inc_d);
          end
        end
        ST_DONE: begin
          // Result is held until taken; the next operand waits one more cycle.
          if (nif.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign nif.in_ready  = in_ready_q;
  assign nif.out_valid = out_valid_q;
  assign nif.out_word  = out_word_q;
  assign nif.out_shift = out_shift_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_norm_seq.sv
// Self-checking bench for norm_seq: directed cases plus randomized operands
// checked against a leading-zero-count reference model.
`timescale 1ns/1ps
module tb_norm_seq;
  import fp_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] got_w;
  logic [4:0]  got_sh;
  int          got_lat;

  norm_seq_if nif();

  norm_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .nif   (nif.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Reference: count leading zeros, clamp by available exponent range.
  function automatic void ref_norm(input logic s, input int e, input logic [23:0] sig,
                                   output logic [31:0] w, output int sh, output int lat);
    int lz, rexp, rl, ce;
    logic [23:0] ns;
    if (sig == 24'd0) begin
      w = {s, 31'd0}; sh = 0; lat = 1;
      return;
    end
    lz = 0;
    while (!sig[23 - lz]) lz++;
    if (e >= 1 && lz <= e - 1) begin
      sh = lz; rexp = e - lz;
    end else begin
      sh = (e >= 1) ? e - 1 : 0; rexp = 0;
    end
    ns = sig << sh;
    w  = {s, rexp[7:0], ns[22:0]};
`ifdef NORM_FAST_EN
    rl = lz; ce = e; lat = 1;
    for (int left = sh; left > 0; ) begin
      if (rl >= 4 && ce >= 5) begin rl -= 4; ce -= 4; left -= 4; end
      else begin rl--; ce--; left--; end
      lat++;
    end
`else
    rl = 0; ce = 0;
    lat = sh + 1 + rl + ce;
`endif
  endfunction

  task automatic run_op(input logic s, input logic [7:0] e, input logic [23:0] sig);
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!nif.in_ready && waitc < 50) begin @(negedge clk); waitc++; end
    nif.in_valid = 1'b1; nif.in_sign = s; nif.in_exp = e; nif.in_sig = sig;
    @(posedge clk); #1;
    nif.in_valid = 1'b0;
    got_lat = 0;
    while (!nif.out_valid && got_lat < 40) begin @(posedge clk); #1; got_lat++; end
    if (!nif.out_valid) got_lat = -1;
    got_w  = nif.out_word;
    got_sh = nif.out_shift;
  endtask

  task automatic release_out();
    @(negedge clk);
    nif.out_ready = 1'b1;
    @(posedge clk); #1;
    nif.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (nif.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", nif.in_ready); end
    total++; if (nif.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", nif.out_valid); end
    total++; if (nif.out_word !== 32'd0) begin bad++; $display("FAIL reset_out_word got=%h want=0", nif.out_word); end
    total++; if (nif.out_shift !== 5'd0) begin bad++; $display("FAIL reset_out_shift got=%0d want=0", nif.out_shift); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (nif.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", nif.in_ready); end
  endtask

  task automatic test_normalized();
    run_op(1'b0, 8'h80, 24'h800000);
    total++; if (got_w !== 32'h40000000) begin bad++; $display("FAIL norm_word got=%h want=40000000", got_w); end
    total++; if (got_sh !== 5'd0) begin bad++; $display("FAIL norm_shift got=%0d want=0", got_sh); end
    total++; if (got_lat !== 1) begin bad++; $display("FAIL norm_latency got=%0d want=1", got_lat); end
    release_out();
  endtask

  task automatic test_deep_shift();
    int want_lat;
`ifdef NORM_FAST_EN
    want_lat = 9;
`else
    want_lat = 24;
`endif
    run_op(1'b0, 8'd100, 24'h000001);
    total++; if (got_w !== 32'h26800000) begin bad++; $display("FAIL deep_word got=%h want=26800000", got_w); end
    total++; if (got_sh !== 5'd23) begin bad++; $display("FAIL deep_shift got=%0d want=23", got_sh); end
    total++; if (got_lat !== want_lat) begin bad++; $display("FAIL deep_latency got=%0d want=%0d", got_lat, want_lat); end
    release_out();
  endtask

  task automatic test_denormal();
    run_op(1'b0, 8'd3, 24'h100000);
    total++; if (got_w !== 32'h00400000) begin bad++; $display("FAIL denorm_word got=%h want=00400000", got_w); end
    total++; if (got_sh !== 5'd2) begin bad++; $display("FAIL denorm_shift got=%0d want=2", got_sh); end
    total++; if (got_lat !== 3) begin bad++; $display("FAIL denorm_latency got=%0d want=3", got_lat); end
    release_out();
    run_op(1'b1, 8'd0, 24'h000400);
    total++; if (got_w !== 32'h80000400) begin bad++; $display("FAIL exp0_word got=%h want=80000400", got_w); end
    total++; if (got_lat !== 1) begin bad++; $display("FAIL exp0_latency got=%0d want=1", got_lat); end
    release_out();
  endtask

  task automatic test_zero();
    run_op(1'b1, 8'h55, 24'h000000);
    total++; if (got_w !== 32'h80000000) begin bad++; $display("FAIL zero_word got=%h want=80000000", got_w); end
    total++; if (got_sh !== 5'd0) begin bad++; $display("FAIL zero_shift got=%0d want=0", got_sh); end
    total++; if (got_lat !== 1) begin bad++; $display("FAIL zero_latency got=%0d want=1", got_lat); end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [31:0] ew;
    int esh, elat, unstable;
    ref_norm(1'b1, 'h90, 24'h00F000, ew, esh, elat);
    run_op(1'b1, 8'h90, 24'h00F000);
    total++; if (got_w !== 32'hC4700000) begin bad++; $display("FAIL bp_word got=%h want=C4700000", got_w); end
    total++; if (got_lat !== elat) begin bad++; $display("FAIL bp_latency got=%0d want=%0d", got_lat, elat); end
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (nif.out_word !== ew || nif.out_valid !== 1'b1 || nif.in_ready !== 1'b0 || busy !== 1'b1) unstable++;
    end
    total++; if (unstable !== 0) begin bad++; $display("FAIL bp_hold unstable_cycles=%0d want=0", unstable); end
    release_out();
    total++; if (nif.out_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop got=%b want=0", nif.out_valid); end
    total++; if (nif.in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready got=%b want=1", nif.in_ready); end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] ew;
    int esh, elat;
    @(negedge clk);
    nif.in_valid = 1'b1; nif.in_sign = 1'b0; nif.in_exp = 8'd100; nif.in_sig = 24'h000001;
    @(posedge clk); #1;
    nif.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (nif.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", nif.out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    total++; if (nif.in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_in_ready got=%b want=0", nif.in_ready); end
    @(negedge clk); rst_n = 1'b1;
    ref_norm(1'b0, 'h7F, 24'h000100, ew, esh, elat);
    run_op(1'b0, 8'h7F, 24'h000100);
    total++; if (got_w !== ew) begin bad++; $display("FAIL rst_after_word got=%h want=%h", got_w, ew); end
    total++; if (got_sh !== 5'(esh)) begin bad++; $display("FAIL rst_after_shift got=%0d want=%0d", got_sh, esh); end
    release_out();
  endtask

  task automatic test_random();
    logic [31:0] ew;
    int esh, elat;
    logic s;
    logic [7:0] e;
    logic [23:0] sig;
    for (int n = 0; n < 40; n++) begin
      s   = 1'($urandom);
      e   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(0, 255));
      sig = 24'($urandom) >> $urandom_range(0, 24);
      ref_norm(s, int'(e), sig, ew, esh, elat);
      run_op(s, e, sig);
      total++; if (got_w !== ew) begin bad++; $display("FAIL rand_word s=%b e=%h sig=%h got=%h want=%h", s, e, sig, got_w, ew); end
      total++; if (got_sh !== 5'(esh)) begin bad++; $display("FAIL rand_shift e=%h sig=%h got=%0d want=%0d", e, sig, got_sh, esh); end
      total++; if (got_lat !== elat) begin bad++; $display("FAIL rand_latency e=%h sig=%h got=%0d want=%0d", e, sig, got_lat, elat); end
      release_out();
    end
  endtask

  initial begin
    nif.in_valid  = 1'b0;
    nif.in_sign   = 1'b0;
    nif.in_exp    = 8'd0;
    nif.in_sig    = 24'd0;
    nif.out_ready = 1'b0;
    test_reset();
    test_normalized();
    test_deep_shift();
    test_denormal();
    test_zero();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
